// File: rtl/i2s_rx.sv
// ---------------------------------------------------------------------------
// i2s_rx : Philips-format I2S receiver
//
// The three serial lines are oversampled on the system clock. Stereo frames
// are deserialised MSB-first, and each completed frame is presented as a
// parallel left/right word pair with a one-cycle valid strobe. clk must run
// at least 4x the BCK frequency.
//
// Optional feature (macro I2S_RX_SLOT_CHECK_EN):
//   When defined, every completed LEFT/RIGHT slot is checked for a length of
//   exactly SLOT_BITS BCK periods. A mismatch pulses slot_err, drops locked
//   and returns the receiver to HUNT. When undefined, slot_err is tied low
//   and any slot length is accepted.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   i2s_bck      in   serial bit clock (asynchronous)
//   i2s_lrck     in   word select (asynchronous), 0 = left, 1 = right
//   i2s_data     in   serial data (asynchronous)
//   left_data    out  last complete left word, two's complement
//   right_data   out  last complete right word, two's complement
//   sample_valid out  one-clk pulse, left_data/right_data updated this cycle
//   locked       out  high while frames are being received
//   slot_err     out  one-clk pulse on a slot-length mismatch
// ---------------------------------------------------------------------------
module i2s_rx #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_BITS  = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i2s_bck,
  input  logic                  i2s_lrck,
  input  logic                  i2s_data,
  output logic [DATA_WIDTH-1:0] left_data,
  output logic [DATA_WIDTH-1:0] right_data,
  output logic                  sample_valid,
  output logic                  locked,
  output logic                  slot_err
);

  // Bit counter holds 0 .. SLOT_BITS+1 (saturating).
  localparam int CNT_W = $clog2(SLOT_BITS + 2);
  // Watchdog holds 0 .. TIMEOUT-1.
  localparam int WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [CNT_W-1:0]      CNT_SAT = CNT_W'(SLOT_BITS + 1);
  localparam logic [WD_W-1:0]       WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [DATA_WIDTH-1:0] MSB_BIT = DATA_WIDTH'(1) << (DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_LEFT,
    ST_RIGHT,
    ST_RSKIP
  } state_t;

  // Synchronisers (stage p0)
  logic r_bck_s1, r_bck_s2, r_bck_h;
  logic r_lrck_s1, r_lrck_s2;
  logic r_data_s1, r_data_s2;

  // Registered rise event with its sampled lines (stage p1)
  logic r_rise_p1;
  logic r_lrck_p1;
  logic r_data_p1;

  // Deserialiser / FSM state (stage p2)
  state_t                r_state;
  logic                  r_lrck_prev;
  logic [CNT_W-1:0]      r_cnt;
  logic [WD_W-1:0]       r_wd;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_shadow;
  logic [DATA_WIDTH-1:0] r_left;
  logic [DATA_WIDTH-1:0] r_right;
  logic                  r_valid;
  logic                  r_locked;

  logic                  w_rise;
  logic                  w_change;
  logic                  w_slot_bad;
  logic [DATA_WIDTH-1:0] w_bit_mask;

  // ---- stage p0: two-flop synchronisers plus BCK history ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bck_s1  <= 1'b0;
      r_bck_s2  <= 1'b0;
      r_bck_h   <= 1'b0;
      r_lrck_s1 <= 1'b0;
      r_lrck_s2 <= 1'b0;
      r_data_s1 <= 1'b0;
      r_data_s2 <= 1'b0;
    end else begin
      r_bck_s1  <= i2s_bck;
      r_bck_s2  <= r_bck_s1;
      r_bck_h   <= r_bck_s2;
      r_lrck_s1 <= i2s_lrck;
      r_lrck_s2 <= r_lrck_s1;
      r_data_s1 <= i2s_data;
      r_data_s2 <= r_data_s1;
    end
  end

  assign w_rise = r_bck_s2 & ~r_bck_h;

  // ---- stage p1: capture lrck/data alongside the rise event ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rise_p1 <= 1'b0;
      r_lrck_p1 <= 1'b0;
      r_data_p1 <= 1'b0;
    end else begin
      r_rise_p1 <= w_rise;
      r_lrck_p1 <= r_lrck_s2;
      r_data_p1 <= r_data_s2;
    end
  end

  // A word-select edge seen at this rise: the bit on this rise is the LSB
  // slot position of the outgoing channel and is discarded.
  assign w_change = r_rise_p1 & (r_lrck_p1 != r_lrck_prev);

  // Walking mask places bit r_cnt MSB-first; it shifts out to zero once
  // r_cnt reaches DATA_WIDTH, so surplus slot bits are ignored for free.
  assign w_bit_mask = MSB_BIT >> r_cnt;

`ifdef I2S_RX_SLOT_CHECK_EN
  // Only slots that began on a real, observed lrck edge are measured; the
  // slot before HUNT resolves and the skipped right slot are of unknown start.
  // The finished slot length counts the LSB position, hence r_cnt + 1.
  assign w_slot_bad = w_change &&
                      ((r_state == ST_LEFT) || (r_state == ST_RIGHT)) &&
                      ((32'(r_cnt) + 32'd1) != 32'(SLOT_BITS));
`else
  assign w_slot_bad = 1'b0;
`endif

  // ---- stage p2: deserialiser, frame FSM and watchdog ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_HUNT;
      r_lrck_prev <= 1'b0;
      r_cnt       <= '0;
      r_wd        <= '0;
      r_shift     <= '0;
      r_shadow    <= '0;
      r_left      <= '0;
      r_right     <= '0;
      r_valid     <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_rise_p1) begin
        // A rise always beats a coincident watchdog expiry.
        r_wd        <= '0;
        r_lrck_prev <= r_lrck_p1;
        if (w_change) begin
          r_cnt   <= '0;
          r_shift <= '0;
          if (w_slot_bad) begin
            r_state  <= ST_HUNT;
            r_locked <= 1'b0;
          end else begin
            case (r_state)
              ST_HUNT:  r_state <= r_lrck_p1 ? ST_RSKIP : ST_LEFT;
              ST_LEFT: begin
                r_shadow <= r_shift;
                r_state  <= ST_RIGHT;
              end
              ST_RIGHT: begin
                // Both words published together so they always pair up.
                r_left   <= r_shadow;
                r_right  <= r_shift;
                r_valid  <= 1'b1;
                r_locked <= 1'b1;
                r_state  <= ST_LEFT;
              end
              ST_RSKIP: r_state <= ST_LEFT;
              default:  r_state <= ST_HUNT;
            endcase
          end
        end else begin
          r_shift <= r_shift | (w_bit_mask & {DATA_WIDTH{r_data_p1}});
          if (r_cnt != CNT_SAT) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end else if (r_wd == WD_LAST) begin
        // Link lost: drop any partial frame, keep the published words.
        r_state  <= ST_HUNT;
        r_locked <= 1'b0;
        r_cnt    <= '0;
        r_shift  <= '0;
      end else begin
        r_wd <= r_wd + 1'b1;
      end
    end
  end

`ifdef I2S_RX_SLOT_CHECK_EN
  logic r_slot_err;

  // Pulse lines up with the cycle a good slot would have been committed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot_err <= 1'b0;
    end else begin
      r_slot_err <= w_slot_bad;
    end
  end

  assign slot_err = r_slot_err;
`else
  assign slot_err = 1'b0;
`endif

  assign left_data    = r_left;
  assign right_data   = r_right;
  assign sample_valid = r_valid;
  assign locked       = r_locked;

endmodule

// File: tb/tb_i2s_rx.sv
// ---------------------------------------------------------------------------
// tb_i2s_rx : self-checking bench for i2s_rx
//
// A behavioural I2S transmitter drives Philips-format slots (MSB one BCK
// after the lrck edge, LSB on the rise that carries the next lrck edge).
// Expected word pairs are pushed to a scoreboard as frames are sent and
// popped by a monitor whenever sample_valid pulses. clk = 8x BCK.
// ---------------------------------------------------------------------------
module tb_i2s_rx;

  localparam int DW = 24;
  localparam int SB = 32;
  localparam int TO = 1024;

  typedef struct packed {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } frame_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          bck = 1'b0;
  logic          lrck = 1'b0;
  logic          sdata = 1'b0;
  logic [DW-1:0] left_data;
  logic [DW-1:0] right_data;
  logic          sample_valid;
  logic          locked;
  logic          slot_err;

  int     n_cmp = 0;
  int     n_err = 0;
  int     n_valid = 0;
  int     n_serr = 0;
  frame_t sbq[$];
  frame_t mon_exp;
  logic   pend = 1'b0;

  i2s_rx #(
    .DATA_WIDTH(DW),
    .SLOT_BITS (SB),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i2s_bck     (bck),
    .i2s_lrck    (lrck),
    .i2s_data    (sdata),
    .left_data   (left_data),
    .right_data  (right_data),
    .sample_valid(sample_valid),
    .locked      (locked),
    .slot_err    (slot_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (!rst && sample_valid === 1'b1) begin
      n_valid++;
      if (sbq.size() == 0) begin
        check("unexpected_valid", 32'(sbq.size()), 32'd1);
      end else begin
        mon_exp = sbq.pop_front();
        check("left_data", 32'(left_data), 32'(mon_exp.l));
        check("right_data", 32'(right_data), 32'(mon_exp.r));
        check("locked_at_valid", 32'(locked), 32'd1);
      end
    end
    if (!rst && slot_err === 1'b1) n_serr++;
  end

  // Bit k (0 = MSB) of a slot carrying an sbits-wide sample, zero padded.
  function automatic logic slot_bit(input int k, input logic [31:0] smp, input int sbits);
    if (k < sbits) return smp[sbits-1-k];
    return 1'b0;
  endfunction

  // Word the receiver should capture from an nbits slot: every bit that
  // arrives before the lrck edge, left-aligned; the bit on the edge is lost.
  function automatic logic [DW-1:0] captured(input int nbits, input logic [31:0] smp,
                                              input int sbits);
    logic [DW-1:0] w;
    w = '0;
    for (int k = 0; k < nbits - 1 && k < DW; k++) w[DW-1-k] = slot_bit(k, smp, sbits);
    return w;
  endfunction

  task automatic bck_period(input logic lr, input logic d);
    bck = 1'b0;
    lrck = lr;
    sdata = d;
    #40;
    bck = 1'b1;
    #40;
  endtask

  task automatic send_slot(input logic lr, input int nbits, input logic [31:0] smp,
                           input int sbits);
    bck_period(lr, pend);
    for (int k = 0; k < nbits - 1; k++) bck_period(lr, slot_bit(k, smp, sbits));
    pend = slot_bit(nbits - 1, smp, sbits);
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int nl,
                            input int nr, input int sbits, input bit push);
    send_slot(1'b0, nl, l, sbits);
    send_slot(1'b1, nr, r, sbits);
    if (push) sbq.push_back({captured(nl, l, sbits), captured(nr, r, sbits)});
  endtask

  // One rise carrying the closing lrck 1->0 edge.
  task automatic terminate();
    bck_period(1'b0, pend);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
    repeat (8) @(negedge clk);
    check(tag, 32'(sbq.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_left", 32'(left_data), 32'd0);
    check("rst_right", 32'(right_data), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_slot_err", 32'(slot_err), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: observed time limit reached, required $finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int v0;
    int s0;
    int cyc;

    // ---- reset state ----
    do_reset();

    // ---- T1: basic 32-bit frame ----
    pend = 1'b0;
    v0 = n_valid;
    send_slot(1'b1, SB, 32'h0, 24);
    send_frame(32'h123456, 32'hABCDEF, SB, SB, 24, 1'b1);
    terminate();
    wait_drain("t1_drain");
    check("t1_pulses", 32'(n_valid - v0), 32'd1);
    check("t1_locked", 32'(locked), 32'd1);

    // ---- T2: stream starts mid right slot ----
    do_reset();
    v0 = n_valid;
    send_slot(1'b1, 12, 32'h5A5A5A, 24);
    send_frame(32'h111111, 32'h222222, SB, SB, 24, 1'b1);
    send_frame(32'h876543, 32'h0F0F0F, SB, SB, 24, 1'b1);
    terminate();
    wait_drain("t2_drain");
    check("t2_pulses", 32'(n_valid - v0), 32'd2);

    // ---- T3: 16-bit slots ----
    do_reset();
    v0 = n_valid;
`ifdef I2S_RX_SLOT_CHECK_EN
    send_slot(1'b1, 16, 32'h0, 16);
    send_frame(32'h8001, 32'h7FFE, 16, 16, 16, 1'b0);
    send_frame(32'hC3A5, 32'h1234, 16, 16, 16, 1'b0);
    terminate();
    wait_drain("t3_drain");
    check("t3_pulses", 32'(n_valid - v0), 32'd0);
`else
    send_slot(1'b1, 16, 32'h0, 16);
    send_frame(32'h8001, 32'h7FFE, 16, 16, 16, 1'b1);
    send_frame(32'hC3A5, 32'h1234, 16, 16, 16, 1'b1);
    terminate();
    wait_drain("t3_drain");
    check("t3_pulses", 32'(n_valid - v0), 32'd2);
    check("t3_slot_err_none", 32'(n_serr), 32'd0);
`endif

    // ---- T4: BCK stops, watchdog drops lock, restart recovers ----
    do_reset();
    v0 = n_valid;
    send_slot(1'b1, SB, 32'h0, 24);
    send_frame(32'h0A1B2C, 32'h3D4E5F, SB, SB, 24, 1'b1);
    send_frame(32'h600DF0, 32'h0DDBA1, SB, SB, 24, 1'b1);
    send_slot(1'b0, SB, 32'h777777, 24);
    send_slot(1'b1, 10, 32'h888888, 24);
    wait_drain("t4_drain_a");
    check("t4_locked_before", 32'(locked), 32'd1);
    cyc = 0;
    while (locked === 1'b1 && cyc < TO + 500) begin
      @(negedge clk);
      cyc++;
    end
    check("t4_locked_lost", 32'(locked), 32'd0);
    check("t4_timeout_window", 32'(cyc >= TO - 24 && cyc <= TO + 24), 32'd1);
    check("t4_left_hold", 32'(left_data), 32'h600DF0);
    check("t4_right_hold", 32'(right_data), 32'h0DDBA1);
    send_frame(32'h13579B, 32'h2468AC, SB, SB, 24, 1'b1);
    terminate();
    wait_drain("t4_drain_b");
    check("t4_pulses", 32'(n_valid - v0), 32'd3);
    check("t4_relocked", 32'(locked), 32'd1);

    // ---- T5: one 31-bit right slot ----
    do_reset();
    v0 = n_valid;
    s0 = n_serr;
    send_slot(1'b1, SB, 32'h0, 24);
`ifdef I2S_RX_SLOT_CHECK_EN
    send_frame(32'h0A0A0A, 32'h050505, SB, SB - 1, 24, 1'b0);
    send_slot(1'b0, SB, 32'h121212, 24);
    check("t5_locked_dropped", 32'(locked), 32'd0);
    check("t5_slot_err_count", 32'(n_serr - s0), 32'd1);
    send_slot(1'b1, SB, 32'h343434, 24);
    send_frame(32'h565656, 32'h787878, SB, SB, 24, 1'b1);
    terminate();
    wait_drain("t5_drain");
    check("t5_pulses", 32'(n_valid - v0), 32'd1);
`else
    send_frame(32'h0A0A0A, 32'h050505, SB, SB - 1, 24, 1'b1);
    send_frame(32'h121212, 32'h343434, SB, SB, 24, 1'b1);
    terminate();
    wait_drain("t5_drain");
    check("t5_pulses", 32'(n_valid - v0), 32'd2);
    check("t5_slot_err_count", 32'(n_serr - s0), 32'd0);
    check("t5_locked", 32'(locked), 32'd1);
`endif

    // ---- T6: reset mid left slot ----
    do_reset();
    send_slot(1'b1, SB, 32'h0, 24);
    send_frame(32'hFEDCBA, 32'h654321, SB, SB, 24, 1'b1);
    bck_period(1'b0, pend);
    for (int k = 0; k < 10; k++) bck_period(1'b0, slot_bit(k, 32'h9ABCDE, 24));
    wait_drain("t6_drain_a");
    check("t6_locked_before", 32'(locked), 32'd1);
    do_reset();
    v0 = n_valid;
    for (int k = 10; k < SB - 1; k++) bck_period(1'b0, slot_bit(k, 32'h9ABCDE, 24));
    pend = 1'b0;
    send_slot(1'b1, SB, 32'h112233, 24);
    send_frame(32'h445566, 32'h778899, SB, SB, 24, 1'b1);
    terminate();
    wait_drain("t6_drain_b");
    check("t6_pulses", 32'(n_valid - v0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
